i2s_tx_framer: RTL and testbench

- Output stage of the audio path. Sits directly downstream of the DSP and consumes its processed packet stream (packet plus one-cycle "changed" strobe).
- Buffers packets in a 2-entry FIFO and serializes them as a standard I2S frame (WS-leads-MSB-by-one-bit format) toward the codec.
- Runs entirely in the sclk domain, so no clock-domain crossing is needed between the DSP and the codec.

---
 rtl/i2s_tx_framer.sv | 101 ++++++++++
 tb/tb_i2s_tx_framer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_framer.sv
// i2s_tx_framer: 2-entry packet FIFO feeding an I2S (WS-leads-MSB) serializer.
// Every flop moves on the falling sclk edge so the codec samples on the rise.
module i2s_tx_framer #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             sclk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] leftPkt_i,
    input  logic [WIDTH-1:0] rightPkt_i,
    input  logic             pktValid_i,
    output logic             ws_o,
    output logic             sdata_o,
    output logic             frameStart_o,
    output logic [1:0]       fifoLevel_o,
    output logic             underflow_o,
    output logic             overflow_o
);
    localparam int FW = 2 * WIDTH;
    localparam int CW = $clog2(FW);
    localparam logic [CW-1:0] CNT_LAST = CW'(FW - 1);
    localparam logic [CW-1:0] WS_FIRST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] WS_LAST  = CW'(FW - 2);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [FW-1:0] shreg;
    logic [FW-1:0] held;
    logic [FW-1:0] frame;
    logic [FW-1:0] mem [FIFO_DEPTH];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    level;
    logic          primed;
    logic          wrap;
    logic          pop;
    logic          full;
    logic          push;
    logic          drop;
    logic          ws_nxt;

    always_comb begin
        wrap    = (cnt == CNT_LAST);
        cnt_nxt = wrap ? '0 : cnt + CW'(1);
        pop     = wrap && (level != 2'd0);
        full    = (level == 2'd2);
        // a pop on the wrap edge frees a slot for a same-edge push
        push    = pktValid_i && (!full || pop);
        drop    = pktValid_i && full && !pop;
        ws_nxt  = (cnt_nxt >= WS_FIRST) && (cnt_nxt <= WS_LAST);
        frame   = pop ? mem[rd_ptr] : held;
    end

    always_ff @(negedge sclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt          <= CNT_LAST;
            shreg        <= '0;
            held         <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            level        <= 2'd0;
            primed       <= 1'b0;
            ws_o         <= 1'b0;
            frameStart_o <= 1'b0;
            underflow_o  <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            ws_o         <= ws_nxt;
            frameStart_o <= wrap;
            shreg        <= wrap ? frame : {shreg[FW-2:0], 1'b0};
            if (wrap) begin
                held <= frame;
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
                primed <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            level <= level + {1'b0, push} - {1'b0, pop};
            if (drop) begin
                overflow_o <= 1'b1;
            end
            if (wrap && (level == 2'd0) && primed) begin
                underflow_o <= 1'b1;
            end
        end
    end

    always_ff @(negedge sclk_i) begin
        if (push) begin
            mem[wr_ptr] <= {leftPkt_i, rightPkt_i};
        end
    end

    assign sdata_o     = shreg[FW-1];
    assign fifoLevel_o = level;

endmodule

// File: tb/tb_i2s_tx_framer.sv
// Bench for i2s_tx_framer: directed scenarios plus randomized pushes
// checked against a queue-based frame model.
module tb_i2s_tx_framer;
    localparam int W  = 16;
    localparam int FW = 2 * W;

    logic          sclk  = 1'b1;
    logic          rst_n = 1'b0;
    logic [W-1:0]  lpk   = '0;
    logic [W-1:0]  rpk   = '0;
    logic          pv    = 1'b0;
    logic          ws;
    logic          sd;
    logic          fs;
    logic [1:0]    lvl;
    logic          unf;
    logic          ovf;
    logic [6:0]    act;

    int total = 0;
    int bad   = 0;

    always #5 sclk = ~sclk;

    i2s_tx_framer #(.WIDTH(W), .FIFO_DEPTH(2)) dut (
        .sclk_i      (sclk),
        .rst_n_i     (rst_n),
        .leftPkt_i   (lpk),
        .rightPkt_i  (rpk),
        .pktValid_i  (pv),
        .ws_o        (ws),
        .sdata_o     (sd),
        .frameStart_o(fs),
        .fifoLevel_o (lvl),
        .underflow_o (unf),
        .overflow_o  (ovf)
    );

    assign act = {ws, sd, fs, lvl, unf, ovf};

    // Reference model: position in frame, queue of packets, frame on the wire.
    int            m_pos = FW - 1;
    logic [FW-1:0] m_q[$];
    logic [FW-1:0] m_frame = '0;
    bit            m_primed = 1'b0;
    bit            m_unf = 1'b0;
    bit            m_ovf = 1'b0;

    always @(negedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = FW - 1;
            m_q.delete();
            m_frame  = '0;
            m_primed = 1'b0;
            m_unf    = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            if (m_pos == FW - 1) begin
                if (m_q.size() > 0) m_frame = m_q.pop_front();
                else if (m_primed) m_unf = 1'b1;
            end
            m_pos = (m_pos + 1) % FW;
            if (pv) begin
                if (m_q.size() < 2) begin
                    m_q.push_back({lpk, rpk});
                    m_primed = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    function automatic logic [6:0] expv();
        logic w;
        w = (m_pos >= W - 1) && (m_pos <= FW - 2);
        return {w, m_frame[FW-1-m_pos], m_pos == 0, 2'(m_q.size()), m_unf, m_ovf};
    endfunction

    task automatic do_reset();
        pv = 1'b0;
        rst_n = 1'b0;
        @(posedge sclk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        pv  = v;
        lpk = a;
        rpk = b;
        @(posedge sclk);
        pv = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FW && !ok; i++) begin
            cyc(1'b0, '0, '0);
            ok = (fs === 1'b1);
        end
    endtask

    task automatic collect(output logic [FW-1:0] w);
        w[FW-1] = sd;
        for (int i = 1; i < FW; i++) begin
            cyc(1'b0, '0, '0);
            w[FW-1-i] = sd;
        end
    endtask

    task automatic test_reset();
        int starts;
        starts = 0;
        do_reset();
        total++;
        if (act !== 7'b0) begin
            bad++;
            $display("FAIL reset_vals got=%b want=%b", act, 7'b0);
        end
        for (int i = 0; i < 3 * FW; i++) begin
            cyc(1'b0, '0, '0);
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL idle_model i=%0d got=%b want=%b", i, act, expv());
            end
            total++;
            if (ws !== (((i % FW) >= W - 1) && ((i % FW) <= FW - 2))) begin
                bad++;
                $display("FAIL idle_ws i=%0d got=%b", i, ws);
            end
            total++;
            if ({sd, unf} !== 2'b00) begin
                bad++;
                $display("FAIL idle_data i=%0d got=%b want=00", i, {sd, unf});
            end
            if (fs === 1'b1) starts++;
        end
        total++;
        if (starts != 3) begin
            bad++;
            $display("FAIL idle_starts got=%0d want=3", starts);
        end
    endtask

    task automatic test_single_push();
        bit ok;
        logic [FW-1:0] w;
        do_reset();
        repeat (5) cyc(1'b0, '0, '0);
        cyc(1'b1, 16'h8001, 16'h7FFE);
        total++;
        if (lvl !== 2'd1) begin
            bad++;
            $display("FAIL push_level got=%0d want=1", lvl);
        end
        wait_frame(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_timeout got=0 want=1");
        end
        total++;
        if (lvl !== 2'd0) begin
            bad++;
            $display("FAIL pop_level got=%0d want=0", lvl);
        end
        collect(w);
        total++;
        if (w !== 32'h8001_7FFE) begin
            bad++;
            $display("FAIL single_data got=%h want=80017ffe", w);
        end
    endtask

    task automatic test_starve();
        bit ok;
        logic [FW-1:0] w;
        do_reset();
        cyc(1'b0, '0, '0);
        cyc(1'b1, 16'h8001, 16'h7FFE);
        for (int f = 0; f < 3; f++) begin
            wait_frame(ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL starve_timeout f=%0d got=0 want=1", f);
            end
            total++;
            if (unf !== (f > 0)) begin
                bad++;
                $display("FAIL starve_underflow f=%0d got=%b want=%b", f, unf, f > 0);
            end
            collect(w);
            total++;
            if (w !== 32'h8001_7FFE) begin
                bad++;
                $display("FAIL starve_data f=%0d got=%h want=80017ffe", f, w);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [FW-1:0] a, b, c, w;
        logic [FW-1:0] want [3];
        a = $urandom;
        b = $urandom;
        c = $urandom;
        if (c == b) c = ~b;
        do_reset();
        cyc(1'b0, '0, '0);
        cyc(1'b1, a[FW-1:W], a[W-1:0]);
        total++;
        if ({lvl, ovf} !== 3'b010) begin
            bad++;
            $display("FAIL ovf_push_a got=%b want=010", {lvl, ovf});
        end
        cyc(1'b1, b[FW-1:W], b[W-1:0]);
        total++;
        if ({lvl, ovf} !== 3'b100) begin
            bad++;
            $display("FAIL ovf_push_b got=%b want=100", {lvl, ovf});
        end
        cyc(1'b1, c[FW-1:W], c[W-1:0]);
        total++;
        if ({lvl, ovf} !== 3'b101) begin
            bad++;
            $display("FAIL ovf_push_c got=%b want=101", {lvl, ovf});
        end
        want[0] = a;
        want[1] = b;
        want[2] = b;
        for (int f = 0; f < 3; f++) begin
            wait_frame(ok);
            collect(w);
            total++;
            if (!ok || w !== want[f]) begin
                bad++;
                $display("FAIL ovf_frame f=%0d got=%h want=%h", f, w, want[f]);
            end
        end
    endtask

    task automatic test_full_wrap();
        bit ok;
        logic [FW-1:0] a, b, c, w;
        logic [FW-1:0] want [3];
        a = $urandom;
        b = $urandom;
        c = $urandom;
        do_reset();
        cyc(1'b0, '0, '0);
        cyc(1'b1, a[FW-1:W], a[W-1:0]);
        cyc(1'b1, b[FW-1:W], b[W-1:0]);
        while (m_pos != FW - 1) cyc(1'b0, '0, '0);
        cyc(1'b1, c[FW-1:W], c[W-1:0]);
        total++;
        if ({fs, lvl, ovf} !== 4'b1100) begin
            bad++;
            $display("FAIL wrap_push got=%b want=1100", {fs, lvl, ovf});
        end
        want[0] = a;
        want[1] = b;
        want[2] = c;
        for (int f = 0; f < 3; f++) begin
            ok = 1'b1;
            if (f > 0) wait_frame(ok);
            collect(w);
            total++;
            if (!ok || w !== want[f]) begin
                bad++;
                $display("FAIL wrap_frame f=%0d got=%h want=%h", f, w, want[f]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [FW-1:0] w;
        do_reset();
        cyc(1'b0, '0, '0);
        cyc(1'b1, 16'hA5A5, 16'h5A5A);
        while (m_pos != 20) cyc(1'b0, '0, '0);
        total++;
        if ({ws, lvl} !== 3'b101) begin
            bad++;
            $display("FAIL pre_reset got=%b want=101", {ws, lvl});
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (act !== 7'b0) begin
            bad++;
            $display("FAIL async_reset got=%b want=%b", act, 7'b0);
        end
        #1;
        rst_n = 1'b1;
        cyc(1'b0, '0, '0);
        total++;
        if ({fs, sd} !== 2'b10) begin
            bad++;
            $display("FAIL post_reset_start got=%b want=10", {fs, sd});
        end
        collect(w);
        total++;
        if ({w, lvl, unf} !== '0) begin
            bad++;
            $display("FAIL post_reset_frame got=%h/%0d/%b want=0", w, lvl, unf);
        end
    endtask

    task automatic test_random();
        int rate;
        logic v;
        do_reset();
        for (int i = 0; i < 12 * FW; i++) begin
            rate = (i / FW) % 3;
            v = (rate == 0) ? 1'b0 : ((rate == 1) ? ($urandom_range(0, 15) == 0)
                                                  : ($urandom_range(0, 3) == 0));
            cyc(v, 16'($urandom), 16'($urandom));
            total++;
            if (act !== expv()) begin
                bad++;
                $display("FAIL rand_cycle i=%0d got=%b want=%b", i, act, expv());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge sclk);
        test_reset();
        test_single_push();
        test_starve();
        test_overflow();
        test_full_wrap();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
